sync_fifo_ctrl: RTL and testbench

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_storage.sv | 39 +++
 rtl/sync_fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and pointer type for the synchronous FIFO controller.
// Optional error flags are enabled with the FIFO_ERR_FLAGS_EN macro (see sync_fifo_ctrl).
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 3;

  // One extra MSB beyond the storage index acts as the wrap bit.
  typedef logic [DEFAULT_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/fifo_storage.sv
// FIFO word array: synchronous write, registered read, no reset on the array itself.
// A same-edge read and write to one index returns the word held before the write.
module fifo_storage
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register is cleared on reset and otherwise holds until the next read.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy count, status flags and handshakes.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they are tied low.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = AEMPTY_THRESH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                rdValid_q;
  logic                pushOk, popOk;

  assign empty        = (wrPtr_q == rdPtr_q);
  assign full         = (wrPtr_q[ADDR_WIDTH-1:0] == rdPtr_q[ADDR_WIDTH-1:0]) &&
                        (wrPtr_q[ADDR_WIDTH] != rdPtr_q[ADDR_WIDTH]);
  assign almost_full  = (count_q >= AFULL_LVL);
  assign almost_empty = (count_q <= AEMPTY_LVL);
  assign count        = count_q;
  assign rd_valid     = rdValid_q;

  // A pop never bypasses an in-cycle push, but a push into a full FIFO may ride on a pop.
  assign popOk  = rd_en && !empty;
  assign pushOk = wr_en && (!full || popOk);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (popOk) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
    case ({pushOk, popOk})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      rdValid_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      rdValid_q <= popOk;
    end
  end

  // Storage writes and reads are suppressed during reset so reset wins over both requests.
  fifo_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_storage (
    .clk_i   (wr_clk),
    .reset_i (reset),
    .we_i    (pushOk && !reset),
    .waddr_i (wrPtr_q[ADDR_WIDTH-1:0]),
    .wdata_i (write_data),
    .re_i    (popOk && !reset),
    .raddr_i (rdPtr_q[ADDR_WIDTH-1:0]),
    .rdata_o (read_data)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && !pushOk) begin
        overflow_q <= 1'b1;
      end
      if (rd_en && !popOk) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: directed vector table, corner-case sequences and
// random traffic against a queue-based reference; honours FIFO_ERR_FLAGS_EN for the error flags.
module tb_sync_fifo_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          wr_clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] write_data = '0;

  logic [DW-1:0] read_data, read_data_t;
  logic          rd_valid, rd_valid_t;
  logic          full, full_t, empty, empty_t;
  logic          almost_full, almost_full_t, almost_empty, almost_empty_t;
  logic [AW:0]   count, count_t;
  logic          overflow, overflow_t, underflow, underflow_t;

  int assertCount = 0;
  int failCount   = 0;

  always #5 wr_clk = ~wr_clk;

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .wr_clk(wr_clk), .reset(reset), .wr_en(wr_en), .write_data(write_data), .rd_en(rd_en),
    .read_data(read_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // Second instance exercises non-default almost-full / almost-empty thresholds.
  sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(6), .AEMPTY_THRESH(2)) dutT (
    .wr_clk(wr_clk), .reset(reset), .wr_en(wr_en), .write_data(write_data), .rd_en(rd_en),
    .read_data(read_data_t), .rd_valid(rd_valid_t), .full(full_t), .empty(empty_t),
    .almost_full(almost_full_t), .almost_empty(almost_empty_t), .count(count_t),
    .overflow(overflow_t), .underflow(underflow_t)
  );

  logic [DW-1:0] modelQ[$];
  logic [DW-1:0] mRdata = '0;
  logic          mValid = 1'b0;
  logic          mOvf = 1'b0;
  logic          mUdf = 1'b0;

  typedef struct {
    logic          r, w, rd;
    logic [DW-1:0] d;
    int            expCount;
    logic          expFull, expEmpty, expValid;
    logic [DW-1:0] expRdata;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic r, w, rd, input logic [DW-1:0] d, input int c,
                              input logic f, e, v, input logic [DW-1:0] rdata);
    vec_t x;
    x.r = r; x.w = w; x.rd = rd; x.d = d; x.expCount = c;
    x.expFull = f; x.expEmpty = e; x.expValid = v; x.expRdata = rdata;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour: the FIFO is just an ordered queue of at most DEPTH words.
  task automatic modelStep(input logic r, w, rd, input logic [DW-1:0] d);
    bit popOk, pushOk;
    if (r) begin
      modelQ.delete();
      mRdata = '0; mValid = 1'b0; mOvf = 1'b0; mUdf = 1'b0;
    end else begin
      popOk  = rd && (modelQ.size() > 0);
      pushOk = w && ((modelQ.size() < DEPTH) || popOk);
      mValid = popOk;
      if (popOk) mRdata = modelQ.pop_front();
      if (pushOk) modelQ.push_back(d);
`ifdef FIFO_ERR_FLAGS_EN
      if (w && !pushOk) mOvf = 1'b1;
      if (rd && !popOk) mUdf = 1'b1;
`endif
    end
  endtask

  task automatic checkOutput();
    int sz;
    sz = modelQ.size();
    check("count",         32'(count),          32'(sz));
    check("full",          32'(full),           32'(sz == DEPTH));
    check("empty",         32'(empty),          32'(sz == 0));
    check("almostFull",    32'(almost_full),    32'(sz >= DEPTH - 1));
    check("almostEmpty",   32'(almost_empty),   32'(sz <= 1));
    check("rdValid",       32'(rd_valid),       32'(mValid));
    check("readData",      read_data,           mRdata);
    check("overflow",      32'(overflow),       32'(mOvf));
    check("underflow",     32'(underflow),      32'(mUdf));
    check("countT",        32'(count_t),        32'(sz));
    check("readDataT",     read_data_t,         mRdata);
    check("almostFullT",   32'(almost_full_t),  32'(sz >= 6));
    check("almostEmptyT",  32'(almost_empty_t), 32'(sz <= 2));
  endtask

  task automatic applyStimulus(input logic r, w, rd, input logic [DW-1:0] d);
    reset = r; wr_en = w; rd_en = rd; write_data = d;
    @(posedge wr_clk);
    modelStep(r, w, rd, d);
    #1;
    checkOutput();
  endtask

  initial begin
    int nextOut;

    vecs[0] = mk(1, 0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
    for (int i = 1; i <= 8; i++)
      vecs[i] = mk(0, 1, 0, 32'(32'h11 * i), i, i == 8, 0, 0, 32'h0);
    vecs[9]  = mk(0, 1, 0, 32'h99, 8, 1, 0, 0, 32'h0);
    vecs[10] = mk(0, 1, 1, 32'h99, 8, 1, 0, 1, 32'h11);
    for (int i = 11; i <= 17; i++)
      vecs[i] = mk(0, 0, 1, 32'h0, 18 - i, 0, 0, 1, 32'(32'h11 * (i - 9)));
    vecs[18] = mk(0, 0, 1, 32'h0, 0, 0, 1, 1, 32'h99);
    vecs[19] = mk(0, 0, 1, 32'h0, 0, 0, 1, 0, 32'h99);
    vecs[20] = mk(1, 0, 0, 32'h0, 0, 0, 1, 0, 32'h0);
    vecs[21] = mk(0, 0, 1, 32'h0, 0, 0, 1, 0, 32'h0);

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].r, vecs[i].w, vecs[i].rd, vecs[i].d);
      check($sformatf("vec%0d.count", i), 32'(count),    32'(vecs[i].expCount));
      check($sformatf("vec%0d.full", i),  32'(full),     32'(vecs[i].expFull));
      check($sformatf("vec%0d.empty", i), 32'(empty),    32'(vecs[i].expEmpty));
      check($sformatf("vec%0d.valid", i), 32'(rd_valid), 32'(vecs[i].expValid));
      check($sformatf("vec%0d.rdata", i), read_data,     vecs[i].expRdata);
    end

    // Twenty words streamed through depth 8 must come out in order across pointer wrap.
    applyStimulus(1, 0, 0, 0);
    nextOut = 0;
    for (int i = 0; i < 28; i++) begin
      applyStimulus(0, i < 20, i >= 3, 32'(i));
      if (rd_valid) begin
        check("wrapOrder", read_data, 32'(nextOut));
        nextOut++;
      end
    end
    check("wrapCount", 32'(nextOut), 32'd20);
    check("wrapEmpty", 32'(empty), 32'd1);

    // Reset with a pop in flight at count 4 abandons that pop.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 32'(32'hA0 + i));
    applyStimulus(0, 0, 1, 0);
    check("inflightCount", 32'(count), 32'd4);
    applyStimulus(1, 0, 1, 0);
    check("rstValid", 32'(rd_valid), 32'd0);
    check("rstCount", 32'(count), 32'd0);
    check("rstEmpty", 32'(empty), 32'd1);

    // Fill and drain for the threshold instance.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 1, 0, 32'(i));
      check("fillAfullT", 32'(almost_full_t), 32'(i >= 6));
    end
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(0, 0, 1, 0);
      check("drainAemptyT", 32'(almost_empty_t), 32'(i <= 2));
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
